// File: rtl/img_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit-wide CNN input RAM, one bit per cycle,
// with a one-byte hold buffer; pulses img_rdy per full frame and holds off until core_done.
module img_loader #(
  parameter int NUM_BITS = 784,
  parameter int ADDR_W   = 10,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  input  logic              core_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              img_rdy,
  output logic              busy,
  output logic              ovf,
  output logic              timeout
);

  localparam int BC_W  = ADDR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_MAX  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        k_q, k_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_v_q, hold_v_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wdata_q, ram_wdata_d;
  logic              img_rdy_q, img_rdy_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    k_d         = k_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    idle_d      = idle_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    img_rdy_d   = 1'b0;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_rdy) begin
          sr_d    = rx_data;
          k_d     = 3'd0;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = bit_cnt_q[ADDR_W-1:0];
        ram_wdata_d = sr_q[k_q];
        bit_cnt_d   = bit_cnt_q + BC_W'(1);
        k_d         = k_q + 3'd1;
        if (k_q == 3'd7) begin
          if (bit_cnt_q == LAST_BIT) begin
            // Frame complete: any held or arriving byte is surplus.
            img_rdy_d = 1'b1;
            state_d   = S_DONE;
            hold_v_d  = 1'b0;
            if (hold_v_q || rx_rdy) ovf_d = 1'b1;
          end else if (hold_v_q) begin
            sr_d     = hold_q;
            hold_v_d = 1'b0;
            if (rx_rdy) ovf_d = 1'b1;
          end else if (rx_rdy) begin
            // Byte arriving with bit 7 bypasses the hold register straight into sr.
            sr_d = rx_data;
          end else begin
            idle_d  = '0;
            state_d = S_GAP;
          end
        end else if (rx_rdy) begin
          if (hold_v_q) begin
            ovf_d = 1'b1;
          end else begin
            hold_d   = rx_data;
            hold_v_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (rx_rdy) begin
          sr_d    = rx_data;
          k_d     = 3'd0;
          idle_d  = '0;
          state_d = S_SHIFT;
        end else if (idle_q == GAP_MAX) begin
          timeout_d = 1'b1;
          bit_cnt_d = '0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (rx_rdy) ovf_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (rx_rdy) ovf_d = 1'b1;
        if (core_done) begin
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      k_q         <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      idle_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 1'b0;
      img_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      idle_q      <= idle_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      img_rdy_q   <= img_rdy_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign img_rdy   = img_rdy_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_img_loader.sv
// Directed bench for img_loader: a RAM model captures writes; each step checks the
// result with an immediate assertion against hand-derived values.
module tb_img_loader;

  localparam int NB = 784;
  localparam int TO = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       core_done;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_wdata;
  logic       img_rdy;
  logic       busy;
  logic       ovf;
  logic       timeout;

  img_loader #(.NUM_BITS(NB), .ADDR_W(10), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .RST_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .core_done (core_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .img_rdy   (img_rdy),
    .busy      (busy),
    .ovf       (ovf),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic ram_m  [0:1023];
  int   wr_cyc [0:1023];
  int   we_cnt = 0, rdy_cnt = 0, rdy_cyc = 0, to_cnt = 0, to_cyc = 0;
  int   total = 0, bad = 0, strobe_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered outputs are stable at the falling edge and describe the next RAM write.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      ram_m[ram_addr]  <= ram_wdata;
      wr_cyc[ram_addr] <= cyc;
      we_cnt           <= we_cnt + 1;
    end
    if (img_rdy === 1'b1) begin
      rdy_cnt <= rdy_cnt + 1;
      rdy_cyc <= cyc;
    end
    if (timeout === 1'b1) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  function automatic logic [7:0] img_byte(input int f, input int i);
    int v;
    v = (i * 29 + f * 71 + 13) ^ (i >> 2);
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; the strobe is sampled at the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data    = b;
    rx_rdy     = 1'b1;
    strobe_cyc = cyc + 1;
    @(negedge clk);
    rx_rdy     = 1'b0;
  endtask

  task automatic send_frame(input int f, input int first, input int last, input int gap);
    for (int unsigned i = first; i <= last; i++) begin
      send_byte(img_byte(f, int'(i)));
      idle(gap);
    end
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    idle(1);
    core_done = 1'b0;
    idle(1);
  endtask

  task automatic check_img(input string tag, input int f);
    int         errs;
    logic [7:0] b;
    errs = 0;
    for (int unsigned a = 0; a < NB; a++) begin
      b = img_byte(f, int'(a / 8));
      if (ram_m[a] !== b[a % 8]) errs++;
    end
    chk(tag, 32'(errs), 0);
  endtask

  function automatic logic [7:0] ram_byte(input int base);
    logic [7:0] p;
    for (int unsigned j = 0; j < 8; j++) p[j] = ram_m[base + int'(j)];
    return p;
  endfunction

  function automatic logic [31:0] outs();
    return 32'({ram_we, ram_addr, ram_wdata, img_rdy, busy, ovf, timeout});
  endfunction

  int b_we, b_rdy, b_to, s1, s0, last_s;

  initial begin
    rst_n     = 1'b0;
    rx_data   = '0;
    rx_rdy    = 1'b0;
    core_done = 1'b0;
    idle(3);
    chk("rst_outs", outs(), 0);
    rst_n = 1'b1;
    idle(2);

    // T1: full frame at 11-cycle byte spacing
    b_we  = we_cnt;
    b_rdy = rdy_cnt;
    send_frame(0, 0, 97, 10);
    check_img("t1_img", 0);
    chk("t1_rdy_cnt", 32'(rdy_cnt - b_rdy), 1);
    chk("t1_rdy_lat", 32'(rdy_cyc - strobe_cyc), 8);
    chk("t1_we_cnt", 32'(we_cnt - b_we), 784);
    chk("t1_ovf", 32'(ovf), 0);
    chk("t1_busy_wait", 32'(busy), 1);
    chk("t1_no_to", 32'(to_cnt), 0);
    pulse_done();
    chk("t1_busy_clr", 32'(busy), 0);

    // T2: LSB-first unpacking
    send_byte(8'h01);
    idle(12);
    send_byte(8'hA5);
    idle(12);
    chk("t2_byte0", 32'(ram_byte(0)), 32'h01);
    chk("t2_byte1", 32'(ram_byte(8)), 32'hA5);
    chk("t2_busy", 32'(busy), 1);

    // T3: three back-to-back strobes, third is dropped
    b_we = we_cnt;
    send_byte(8'h3C);
    s1 = strobe_cyc;
    send_byte(8'hC3);
    send_byte(8'h77);
    idle(25);
    chk("t3_we_cnt", 32'(we_cnt - b_we), 16);
    chk("t3_first_wr", 32'(wr_cyc[16] - s1), 1);
    chk("t3_b2b", 32'(wr_cyc[31] - wr_cyc[16]), 15);
    chk("t3_byte2", 32'(ram_byte(16)), 32'h3C);
    chk("t3_byte3", 32'(ram_byte(24)), 32'hC3);
    chk("t3_ovf", 32'(ovf), 1);

    // T4: 40 bytes in total, then an inter-byte gap long enough to abort
    b_to  = to_cnt;
    b_rdy = rdy_cnt;
    send_frame(4, 4, 39, 10);
    last_s = strobe_cyc;
    idle(TO + 10);
    chk("t4_to_cnt", 32'(to_cnt - b_to), 1);
    chk("t4_to_lat", 32'(to_cyc - last_s), 32'(TO + 8));
    chk("t4_busy", 32'(busy), 0);
    chk("t4_no_rdy", 32'(rdy_cnt - b_rdy), 0);
    b_we = we_cnt;
    send_frame(1, 0, 97, 7);
    idle(4);
    check_img("t4_img", 1);
    chk("t4_rdy_cnt", 32'(rdy_cnt - b_rdy), 1);
    chk("t4_rdy_lat", 32'(rdy_cyc - strobe_cyc), 8);
    chk("t4_we_cnt", 32'(we_cnt - b_we), 784);
    chk("t4_ovf", 32'(ovf), 0);
    chk("t4_to_once", 32'(to_cnt - b_to), 1);

    // T5: surplus bytes while waiting for the core
    b_we  = we_cnt;
    b_rdy = rdy_cnt;
    for (int unsigned i = 0; i < 5; i++) begin
      send_byte(8'hF0 + 8'(i));
      idle(2);
    end
    chk("t5_no_we", 32'(we_cnt - b_we), 0);
    chk("t5_ovf", 32'(ovf), 1);
    chk("t5_busy", 32'(busy), 1);
    chk("t5_no_rdy", 32'(rdy_cnt - b_rdy), 0);
    pulse_done();
    chk("t5_busy_clr", 32'(busy), 0);
    send_frame(2, 0, 9, 7);
    idle(5);
    pulse_done();
    chk("t5_done_ignored", 32'(busy), 1);
    send_frame(2, 10, 97, 7);
    idle(4);
    check_img("t5_img", 2);
    chk("t5_rdy_cnt", 32'(rdy_cnt - b_rdy), 1);
    chk("t5_ovf_clr", 32'(ovf), 0);
    pulse_done();

    // T6: reset in the middle of byte 50
    send_frame(3, 0, 48, 7);
    send_byte(img_byte(3, 49));
    idle(3);
    chk("t6_pre_we", 32'(ram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", outs(), 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    b_rdy = rdy_cnt;
    send_byte(img_byte(0, 0));
    s0 = strobe_cyc;
    idle(7);
    send_frame(0, 1, 96, 7);
    idle(10);
    chk("t6_no_early_rdy", 32'(rdy_cnt - b_rdy), 0);
    send_byte(img_byte(0, 97));
    idle(12);
    chk("t6_addr0", 32'(wr_cyc[0] - s0), 1);
    chk("t6_rdy_cnt", 32'(rdy_cnt - b_rdy), 1);
    chk("t6_rdy_lat", 32'(rdy_cyc - strobe_cyc), 8);
    check_img("t6_img", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
